// File: rtl/wb_pkg.sv
// Shared constants and the ack-pipeline stage type for the Wishbone SRAM slave.
package wb_pkg;

    localparam int STALL_W   = 8;
    localparam int LAT_MIN   = 1;
    localparam int LAT_MAX   = 4;
    // Stage data is carried at a fixed maximum width so the struct can live here;
    // the top level zero-extends into it and slices back out.
    localparam int DAT_W_MAX = 64;

    typedef struct packed {
        logic                 valid;
        logic                 is_read;
        logic [DAT_W_MAX-1:0] data;
    } wb_stage_t;

endpackage

// File: rtl/wb_ack_pipe.sv
// Fixed-length completion pipeline: shifts every cycle, abort drops all valids.
module wb_ack_pipe
    import wb_pkg::*;
#(
    parameter int latency = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      abort_i,
    input  wb_stage_t stage_i,
    output wb_stage_t stage_o
);

    wb_stage_t pipe_q [latency];

    // Shift stages forward each cycle; an abort invalidates everything in flight,
    // including whatever would have entered this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < latency; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= stage_i;
            for (int i = 1; i < latency; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            if (abort_i) begin
                for (int i = 0; i < latency; i++) begin
                    pipe_q[i].valid <= 1'b0;
                end
            end
        end
    end

    assign stage_o = pipe_q[latency-1];

endmodule

// File: rtl/wb_sram_slave.sv
// Pipelined Wishbone slave with on-chip word memory, fixed ack latency and a
// rotating stall mask for exercising master back-pressure.
module wb_sram_slave
    import wb_pkg::*;
#(
    parameter int                 adr_width     = 16,
    parameter int                 dat_width     = 16,
    parameter int                 mem_words     = 1024,
    parameter int                 latency       = 2,
    parameter logic [STALL_W-1:0] stall_pattern = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cyc,
    input  logic                 stb,
    input  logic                 we,
    input  logic [adr_width-1:0] adr,
    input  logic [dat_width-1:0] dat_i,
    output logic [dat_width-1:0] dat_o,
    output logic                 ack,
    output logic                 stall
);

    localparam int IDX_W = $clog2(mem_words);

    if ((latency < LAT_MIN) || (latency > LAT_MAX)) begin : g_bad_latency
        $error("wb_sram_slave: latency must be within 1..4");
    end
    if ((mem_words < 2) || (mem_words > 65536) || ((mem_words & (mem_words - 1)) != 0)) begin : g_bad_depth
        $error("wb_sram_slave: mem_words must be a power of two in 2..65536");
    end
    if (adr_width < IDX_W) begin : g_bad_adr
        $error("wb_sram_slave: adr_width too narrow for mem_words");
    end
    if ((dat_width < 1) || (dat_width > DAT_W_MAX)) begin : g_bad_dat
        $error("wb_sram_slave: dat_width out of range");
    end

    logic [dat_width-1:0] mem_q [mem_words];
    logic [STALL_W-1:0]   stall_q;
    logic [IDX_W-1:0]     idx;
    logic                 accept;
    wb_stage_t            stage_d;
    wb_stage_t            stage_o;
    logic                 unused_bits;

    // Upper address bits are dropped, so the memory aliases across the address space.
    assign idx    = adr[IDX_W-1:0];
    assign stall  = stall_q[0];
    assign accept = cyc & stb & ~stall_q[0];

    // Stall mask rotates right every cycle whether or not a bus cycle is active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= stall_pattern;
        end else begin
            stall_q <= {stall_q[0], stall_q[STALL_W-1:1]};
        end
    end

    // Write port: memory is never reset, writes land at the accept edge.
    always_ff @(posedge clk) begin
        if (accept && we) begin
            mem_q[idx] <= dat_i;
        end
    end

    // Build the entry stage; read data is captured at the accept edge by the pipe.
    always_comb begin
        stage_d         = '0;
        stage_d.valid   = accept;
        stage_d.is_read = ~we;
        if (!we) begin
            stage_d.data = DAT_W_MAX'(mem_q[idx]);
        end
    end

    wb_ack_pipe #(
        .latency (latency)
    ) u_ack_pipe (
        .clk     (clk),
        .rst     (rst),
        .abort_i (~cyc),
        .stage_i (stage_d),
        .stage_o (stage_o)
    );

    assign ack   = stage_o.valid;
    assign dat_o = (stage_o.valid && stage_o.is_read) ? stage_o.data[dat_width-1:0] : '0;

    assign unused_bits = ^{adr, stage_o.data};

endmodule

// File: tb/tb_wb_sram_slave.sv
// Directed bench: three slaves (lat 2 no stall, lat 2 stall 8'h05, lat 4 no stall).
module tb_wb_sram_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc   [3];
    logic        stb   [3];
    logic        we    [3];
    logic [15:0] adr   [3];
    logic [15:0] dat_w [3];
    logic [15:0] dat_r [3];
    logic        ack   [3];
    logic        stall [3];

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] mdl_stall_b;

    always #5 clk = ~clk;

    wb_sram_slave #(.latency(2), .stall_pattern(8'h00)) u_a (
        .clk(clk), .rst(rst), .cyc(cyc[0]), .stb(stb[0]), .we(we[0]), .adr(adr[0]),
        .dat_i(dat_w[0]), .dat_o(dat_r[0]), .ack(ack[0]), .stall(stall[0]));

    wb_sram_slave #(.latency(2), .stall_pattern(8'h05)) u_b (
        .clk(clk), .rst(rst), .cyc(cyc[1]), .stb(stb[1]), .we(we[1]), .adr(adr[1]),
        .dat_i(dat_w[1]), .dat_o(dat_r[1]), .ack(ack[1]), .stall(stall[1]));

    wb_sram_slave #(.latency(4), .stall_pattern(8'h00)) u_c (
        .clk(clk), .rst(rst), .cyc(cyc[2]), .stb(stb[2]), .we(we[2]), .adr(adr[2]),
        .dat_i(dat_w[2]), .dat_o(dat_r[2]), .ack(ack[2]), .stall(stall[2]));

    // Reference stall rotator for instance B, started from the programmed mask.
    always @(posedge clk or posedge rst) begin
        if (rst) mdl_stall_b <= 8'h05;
        else     mdl_stall_b <= {mdl_stall_b[0], mdl_stall_b[7:1]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // One isolated request on a non-stalling slave; checks the ack slot and the cycle after.
    task automatic single(input int i, input int lat, input bit w, input logic [15:0] a,
                          input logic [15:0] d, input logic [15:0] exp, input string tag);
        cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w; adr[i] = a; dat_w[i] = d;
        tick;
        stb[i] = 1'b0;
        repeat (lat - 1) tick;
        chk({tag, "_ack"}, 32'(ack[i]), 32'd1);
        chk({tag, "_dat"}, 32'(dat_r[i]), w ? 32'd0 : 32'(exp));
        tick;
        chk({tag, "_ack_end"}, 32'(ack[i]), 32'd0);
        cyc[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int  n_acc;
        int  n_ack;
        bit  acc_prev;
        bit  acc_now;

        for (int i = 0; i < 3; i++) begin
            cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; adr[i] = '0; dat_w[i] = '0;
        end
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ack_a",   32'(ack[0]),   32'd0);
        chk("rst_dat_a",   32'(dat_r[0]), 32'd0);
        chk("rst_stall_a", 32'(stall[0]), 32'd0);
        chk("rst_stall_b", 32'(stall[1]), 32'd1);
        chk("rst_ack_c",   32'(ack[2]),   32'd0);
        rst = 1'b0;
        tick;

        // Basic write then read, latency 2.
        single(0, 2, 1'b1, 16'h0010, 16'hA5A5, 16'h0000, "a_wr10");
        single(0, 2, 1'b0, 16'h0010, 16'h0000, 16'hA5A5, "a_rd10");

        // Write and read of the same address on consecutive accepts.
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 16'h0020; dat_w[0] = 16'hBEEF;
        tick;
        we[0] = 1'b0;
        tick;
        chk("a_wr_rd_ack0", 32'(ack[0]),   32'd1);
        chk("a_wr_rd_dat0", 32'(dat_r[0]), 32'd0);
        stb[0] = 1'b0;
        tick;
        chk("a_wr_rd_ack1", 32'(ack[0]),   32'd1);
        chk("a_wr_rd_dat1", 32'(dat_r[0]), 32'hBEEF);
        tick;
        chk("a_wr_rd_idle", 32'(ack[0]),   32'd0);
        cyc[0] = 1'b0;

        // Aliasing: 0x0405 maps onto 0x0005 with 1024 words.
        single(0, 2, 1'b1, 16'h0005, 16'h1234, 16'h0000, "a_alias_wr");
        single(0, 2, 1'b0, 16'h0405, 16'h0000, 16'h1234, "a_alias_rd");

        // Preload 0..7 and burst-read them with stb held.
        for (int i = 0; i < 8; i++) begin
            single(0, 2, 1'b1, 16'(i), 16'(16'h0100 + i), 16'h0000, "a_pre");
        end
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 16'h0000;
        for (int t = 1; t <= 10; t++) begin
            tick;
            if (t >= 2 && t <= 9) begin
                chk("a_burst_ack", 32'(ack[0]),   32'd1);
                chk("a_burst_dat", 32'(dat_r[0]), 32'(16'h0100 + t - 2));
            end else begin
                chk("a_burst_ack", 32'(ack[0]),   32'd0);
                chk("a_burst_dat", 32'(dat_r[0]), 32'd0);
            end
            if (t < 8) adr[0] = 16'(t);
            else       stb[0] = 1'b0;
        end
        cyc[0] = 1'b0;

        // Stalling slave: continuous writes, accepts only in non-stall cycles.
        n_acc = 0; n_ack = 0; acc_prev = 1'b0;
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 16'h0000; dat_w[1] = 16'h0200;
        for (int t = 0; t < 20; t++) begin
            acc_now = !mdl_stall_b[0];
            tick;
            chk("b_stall", 32'(stall[1]), 32'(mdl_stall_b[0]));
            chk("b_ack",   32'(ack[1]),   32'(acc_prev));
            if (ack[1]) n_ack++;
            if (acc_now) begin
                n_acc++;
                adr[1]   = 16'(n_acc);
                dat_w[1] = 16'(16'h0200 + n_acc);
            end
            acc_prev = acc_now;
        end
        stb[1] = 1'b0;
        tick;
        chk("b_ack_tail", 32'(ack[1]), 32'(acc_prev));
        if (ack[1]) n_ack++;
        tick;
        chk("b_ack_idle", 32'(ack[1]), 32'd0);
        chk("b_count",    32'(n_ack),  32'(n_acc));
        cyc[1] = 1'b0;

        // Latency 4: three reads, then cyc drops; nothing may ack.
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; adr[2] = 16'h0000;
        tick;
        adr[2] = 16'h0001;
        tick;
        adr[2] = 16'h0002;
        tick;
        cyc[2] = 1'b0; stb[2] = 1'b0;
        for (int t = 0; t < 6; t++) begin
            tick;
            chk("c_abort_ack", 32'(ack[2]), 32'd0);
        end
        single(2, 4, 1'b1, 16'h0033, 16'h5A5A, 16'h0000, "c_wr");
        single(2, 4, 1'b0, 16'h0033, 16'h0000, 16'h5A5A, "c_rd");

        // Reset with two reads in flight, first ack on the bus.
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 16'h0001;
        tick;
        adr[0] = 16'h0002;
        tick;
        chk("a_pre_rst_ack", 32'(ack[0]),   32'd1);
        chk("a_pre_rst_dat", 32'(dat_r[0]), 32'h0101);
        stb[0] = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("a_rst_ack",   32'(ack[0]),   32'd0);
        chk("a_rst_dat",   32'(dat_r[0]), 32'd0);
        chk("b_rst_stall", 32'(stall[1]), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        chk("b_rel_stall", 32'(stall[1]), 32'd1);
        tick;
        chk("a_post_rst_ack", 32'(ack[0]),   32'd0);
        chk("b_rot_stall",    32'(stall[1]), 32'd0);
        cyc[0] = 1'b0;
        tick;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
